// File: rtl/tug_match_ctrl.sv
// Tug-of-war match controller: sequences rounds, arbitrates human vs CPU presses,
// moves the rope on a one-hot LED playfield and keeps scores until one side wins.
module tug_match_ctrl #(
    parameter int NUM_LEDS    = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                human_press,
    input  logic                cpu_press,
    output logic                cpu_en,
    output logic [NUM_LEDS-1:0] led,
    output logic [SCORE_W-1:0]  human_score,
    output logic [SCORE_W-1:0]  cpu_score,
    output logic [1:0]          state,
    output logic [1:0]          winner
);

    localparam int POS_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [POS_W-1:0]   POS_CENTRE = POS_W'(NUM_LEDS / 2);
    localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]   POS_MIN    = '0;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_HUMAN = 2'b01;
    localparam logic [1:0] WIN_CPU   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [SCORE_W-1:0]   human_score_q, human_score_d;
    logic [SCORE_W-1:0]   cpu_score_q, cpu_score_d;
    logic [1:0]           winner_q, winner_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        return NUM_LEDS'(1) << p;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pos_q         <= POS_CENTRE;
            hold_q        <= '0;
            human_score_q <= '0;
            cpu_score_q   <= '0;
            winner_q      <= WIN_NONE;
            led_q         <= onehot(POS_CENTRE);
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            hold_q        <= hold_d;
            human_score_q <= human_score_d;
            cpu_score_q   <= cpu_score_d;
            winner_q      <= winner_d;
            led_q         <= led_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        hold_d        = hold_q;
        human_score_d = human_score_q;
        cpu_score_d   = cpu_score_q;
        winner_d      = winner_q;
        led_d         = led_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                    pos_d   = POS_CENTRE;
                end
            end

            PLAY: begin
                // Simultaneous presses cancel; pushing past an end scores instead of moving
                if (human_press && !cpu_press) begin
                    if (pos_q == POS_MAX) begin
                        if (human_score_q != SCORE_WIN)
                            human_score_d = human_score_q + 1'b1;
                        state_d = POINT;
                        hold_d  = '0;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (cpu_press && !human_press) begin
                    if (pos_q == POS_MIN) begin
                        if (cpu_score_q != SCORE_WIN)
                            cpu_score_d = cpu_score_q + 1'b1;
                        state_d = POINT;
                        hold_d  = '0;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end

            POINT: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    pos_d  = POS_CENTRE;
                    if (human_score_q == SCORE_WIN) begin
                        state_d  = OVER;
                        winner_d = WIN_HUMAN;
                    end else if (cpu_score_q == SCORE_WIN) begin
                        state_d  = OVER;
                        winner_d = WIN_CPU;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            OVER: begin
                if (start) begin
                    state_d       = PLAY;
                    pos_d         = POS_CENTRE;
                    human_score_d = '0;
                    cpu_score_d   = '0;
                    winner_d      = WIN_NONE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Playfield image is registered alongside the state it belongs to
        case (state_d)
            POINT:   led_d = '0;
            OVER:    led_d = '1;
            default: led_d = onehot(pos_d);
        endcase
    end

    assign cpu_en      = (state_q == PLAY);
    assign led         = led_q;
    assign human_score = human_score_q;
    assign cpu_score   = cpu_score_q;
    assign state       = state_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Directed bench for tug_match_ctrl: vector table for basic play plus
// hand-written sequences for full matches and asynchronous reset.
module tb_tug_match_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       human_press = 1'b0;
    logic       cpu_press = 1'b0;
    logic       cpu_en;
    logic [8:0] led;
    logic [2:0] human_score;
    logic [2:0] cpu_score;
    logic [1:0] state;
    logic [1:0] winner;

    int compared = 0;
    int mismatched = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_POINT = 2'd2, S_OVER = 2'd3;
    localparam logic [8:0] L_C = 9'b000010000;

    tug_match_ctrl #(.NUM_LEDS(9), .WIN_SCORE(7), .HOLD_CYCLES(4), .SCORE_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .human_press(human_press),
        .cpu_press(cpu_press), .cpu_en(cpu_en), .led(led), .human_score(human_score),
        .cpu_score(cpu_score), .state(state), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       h;
        logic       c;
        logic       s;
        logic [1:0] st;
        logic [8:0] led;
        logic [2:0] hs;
        logic [2:0] cs;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic h, c, s, input logic [1:0] st, input logic [8:0] l,
                       input logic [2:0] hs, cs, input logic [1:0] w);
        vec_t v;
        v.h = h; v.c = c; v.s = s; v.st = st; v.led = l; v.hs = hs; v.cs = cs; v.win = w;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(input string tag, input logic [1:0] st, input logic [8:0] l,
                         input logic [2:0] hs, input logic [2:0] cs, input logic [1:0] w);
        cmp({tag, ".state"}, 32'(state), 32'(st));
        cmp({tag, ".led"}, 32'(led), 32'(l));
        cmp({tag, ".human_score"}, 32'(human_score), 32'(hs));
        cmp({tag, ".cpu_score"}, 32'(cpu_score), 32'(cs));
        cmp({tag, ".winner"}, 32'(winner), 32'(w));
        cmp({tag, ".cpu_en"}, 32'(cpu_en), 32'(st == S_PLAY));
    endtask

    task automatic step(input logic h, input logic c, input logic s);
        human_press = h;
        cpu_press   = c;
        start       = s;
        @(posedge clk);
        #1;
        human_press = 1'b0;
        cpu_press   = 1'b0;
        start       = 1'b0;
    endtask

    initial begin
        // IDLE ignores presses; start with a same-cycle press only starts
        add(1, 0, 0, S_IDLE,  L_C,          0, 0, 0);
        add(0, 1, 0, S_IDLE,  L_C,          0, 0, 0);
        add(1, 0, 1, S_PLAY,  L_C,          0, 0, 0);
        add(0, 0, 0, S_PLAY,  L_C,          0, 0, 0);
        // human walks rope to the end, then scores
        add(1, 0, 0, S_PLAY,  9'b000100000, 0, 0, 0);
        add(0, 0, 0, S_PLAY,  9'b000100000, 0, 0, 0);
        add(1, 0, 0, S_PLAY,  9'b001000000, 0, 0, 0);
        add(1, 0, 0, S_PLAY,  9'b010000000, 0, 0, 0);
        add(1, 0, 0, S_PLAY,  9'b100000000, 0, 0, 0);
        add(0, 0, 0, S_PLAY,  9'b100000000, 0, 0, 0);
        add(1, 0, 0, S_POINT, 9'b000000000, 1, 0, 0);
        // hold: presses and start ignored for exactly 4 clocks
        add(1, 0, 1, S_POINT, 9'b000000000, 1, 0, 0);
        add(0, 1, 0, S_POINT, 9'b000000000, 1, 0, 0);
        add(0, 0, 0, S_POINT, 9'b000000000, 1, 0, 0);
        add(0, 0, 0, S_PLAY,  L_C,          1, 0, 0);
        // simultaneous presses cancel; start ignored in PLAY
        add(1, 1, 0, S_PLAY,  L_C,          1, 0, 0);
        add(1, 1, 0, S_PLAY,  L_C,          1, 0, 0);
        add(1, 1, 0, S_PLAY,  L_C,          1, 0, 0);
        add(0, 0, 1, S_PLAY,  L_C,          1, 0, 0);
        // CPU walks to pos 0 and scores without wrapping
        add(0, 1, 0, S_PLAY,  9'b000001000, 1, 0, 0);
        add(0, 1, 0, S_PLAY,  9'b000000100, 1, 0, 0);
        add(0, 1, 0, S_PLAY,  9'b000000010, 1, 0, 0);
        add(0, 1, 0, S_PLAY,  9'b000000001, 1, 0, 0);
        add(0, 1, 0, S_POINT, 9'b000000000, 1, 1, 0);
        add(0, 0, 0, S_POINT, 9'b000000000, 1, 1, 0);
        add(0, 0, 0, S_POINT, 9'b000000000, 1, 1, 0);
        add(0, 0, 0, S_POINT, 9'b000000000, 1, 1, 0);
        add(0, 0, 0, S_PLAY,  L_C,          1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_held", S_IDLE, L_C, 0, 0, 0);
        reset = 1'b0;
        #1;
        check("reset_released", S_IDLE, L_C, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].h, vecs[i].c, vecs[i].s);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].led, vecs[i].hs, vecs[i].cs,
                  vecs[i].win);
        end

        // CPU takes points 2..7 and wins the match
        for (int p = 2; p <= 7; p++) begin
            repeat (5) step(0, 1, 0);
            check($sformatf("cpu_pt%0d", p), S_POINT, 9'h000, 1, 3'(p), 0);
            repeat (4) step(0, 0, 0);
            if (p < 7)
                check($sformatf("cpu_resume%0d", p), S_PLAY, L_C, 1, 3'(p), 0);
            else
                check("cpu_over", S_OVER, 9'h1FF, 1, 7, 2'b10);
        end
        step(1, 0, 0);
        check("over_press", S_OVER, 9'h1FF, 1, 7, 2'b10);
        step(0, 0, 1);
        check("over_restart", S_PLAY, L_C, 0, 0, 0);

        // async reset between edges during the hold
        repeat (5) step(0, 1, 0);
        check("pre_reset_pt", S_POINT, 9'h000, 0, 1, 0);
        step(0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_reset", S_IDLE, L_C, 0, 0, 0);
        #1 reset = 1'b0;
        step(1, 0, 0);
        check("post_reset_idle", S_IDLE, L_C, 0, 0, 0);
        step(0, 0, 1);
        check("post_reset_start", S_PLAY, L_C, 0, 0, 0);

        // human takes 7 straight points
        for (int p = 1; p <= 7; p++) begin
            repeat (5) step(1, 0, 0);
            check($sformatf("hum_pt%0d", p), S_POINT, 9'h000, 3'(p), 0, 0);
            repeat (4) step(0, 0, 0);
        end
        check("hum_over", S_OVER, 9'h1FF, 7, 0, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
